rr_dispatcher: RTL and testbench

Round-robin packet dispatcher: accepts one valid/ready flit stream and distributes whole packets across NUM_OUT output channels, each with its own small FIFO. It performs the inverse of the datapath's round-robin arbitration: the arbiter merges N requesters onto one link, and this block fans one link out to N consumers (e.g. core-side ports) with fair rotation and packet atomicity.

---
 rtl/rr_dispatcher_pkg.sv | 17 +
 rtl/rr_disp_fifo.sv | 58 +++++
 rtl/rr_dispatcher.sv | 145 ++++++++++++++
 tb/tb_rr_dispatcher.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_dispatcher_pkg.sv
// Shared types and default sizing for the round-robin packet dispatcher.
// PTR_W/CNT_W describe the default configuration; the top re-derives them from its parameters.
package rr_dispatcher_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } disp_state_t;

   localparam int DEF_NUM_OUT    = 4;
   localparam int DEF_DATA_W     = 64;
   localparam int DEF_FIFO_DEPTH = 2;

   localparam int PTR_W = $clog2(DEF_NUM_OUT);
   localparam int CNT_W = $clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/rr_disp_fifo.sv
// Per-channel synchronous FIFO with registered storage and no write-to-read bypass.
// A full FIFO refuses a push even when it is being popped in the same cycle.
module rr_disp_fifo
   import rr_dispatcher_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + 1,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int A_W = $clog2(DEPTH);
   localparam int C_W = A_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [A_W-1:0]   r_wptr;
   logic [A_W-1:0]   r_rptr;
   logic [C_W-1:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == C_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rr_dispatcher.sv
// Fans one valid/ready flit stream out to NUM_OUT channel FIFOs, rotating fairly per packet
// and keeping every packet on a single channel.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no packet open; next flit picks a target by round-robin
//   ST_LOCKED | packet open; every flit goes to r_target until in_last
module rr_dispatcher
   import rr_dispatcher_pkg::*;
#(
   parameter int NUM_OUT    = DEF_NUM_OUT,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_disp_enable,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic [DATA_W-1:0]         i_in_data,
   input  logic                      i_in_last,
   output logic [NUM_OUT-1:0]        o_out_valid,
   input  logic [NUM_OUT-1:0]        i_out_ready,
   output logic [NUM_OUT*DATA_W-1:0] o_out_data,
   output logic [NUM_OUT-1:0]        o_out_last
);

   localparam int P_W = $clog2(NUM_OUT);
   localparam int C_W = $clog2(FIFO_DEPTH) + 1;

   disp_state_t        r_state;
   disp_state_t        w_state_nxt;
   logic [P_W-1:0]     r_ptr;
   logic [P_W-1:0]     w_ptr_nxt;
   logic [P_W-1:0]     r_target;
   logic [P_W-1:0]     w_target_nxt;
   logic [P_W-1:0]     w_sel;
   logic [P_W-1:0]     w_tgt;
   logic               w_sel_ok;
   logic               w_accept;

   logic [C_W-1:0]     w_count [NUM_OUT];
   logic [DATA_W:0]    w_rdata [NUM_OUT];
   logic [NUM_OUT-1:0] w_full;
   logic [NUM_OUT-1:0] w_empty;
   logic [NUM_OUT-1:0] w_room;
   logic [NUM_OUT-1:0] w_push;
   logic [NUM_OUT-1:0] w_pop;
   logic [NUM_OUT-1:0] w_cand;
   logic [NUM_OUT-1:0] w_cand_hi;

   // Candidates above the pointer win; otherwise the lowest candidate wraps around.
   always_comb begin
      w_cand    = '0;
      w_cand_hi = '0;
      w_sel     = '0;
      if (i_disp_enable) begin
         w_cand = w_room;
      end else begin
         w_cand[0] = w_room[0];
      end
      for (int i = 0; i < NUM_OUT; i++) begin
         w_cand_hi[i] = w_cand[i] && (P_W'(i) > r_ptr);
      end
      for (int i = NUM_OUT - 1; i >= 0; i--) begin
         if (w_cand[i]) w_sel = P_W'(i);
      end
      for (int i = NUM_OUT - 1; i >= 0; i--) begin
         if (w_cand_hi[i]) w_sel = P_W'(i);
      end
      w_sel_ok = |w_cand;
   end

   assign o_in_ready = rst_n &&
                       (((r_state == ST_IDLE) && w_sel_ok) ||
                        ((r_state == ST_LOCKED) && !w_full[r_target]));
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_tgt      = (r_state == ST_IDLE) ? w_sel : r_target;

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_target_nxt = r_target;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (i_in_last) begin
                  w_ptr_nxt = w_sel;
               end else begin
                  w_state_nxt  = ST_LOCKED;
                  w_target_nxt = w_sel;
               end
            end
         end
         ST_LOCKED: begin
            if (w_accept && i_in_last) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = r_target;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Pointer resets to the last channel so the first packet lands on channel 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_ptr    <= P_W'(NUM_OUT - 1);
         r_target <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_target <= w_target_nxt;
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
      assign w_room[g] = (w_count[g] != C_W'(FIFO_DEPTH));
      assign w_push[g] = w_accept && (w_tgt == P_W'(g));
      assign w_pop[g]  = !w_empty[g] && i_out_ready[g];

      rr_disp_fifo #(
         .WIDTH (DATA_W + 1),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_push[g]),
         .i_wdata ({i_in_last, i_in_data}),
         .i_pop   (w_pop[g]),
         .o_rdata (w_rdata[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g]),
         .o_count (w_count[g])
      );

      assign o_out_valid[g]                  = !w_empty[g];
      assign o_out_last[g]                   = w_rdata[g][DATA_W] && !w_empty[g];
      assign o_out_data[g*DATA_W +: DATA_W]  = w_rdata[g][DATA_W-1:0];
   end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Bench for rr_dispatcher: directed scenarios with fixed expectations, then random traffic
// against a queue-based model of the dispatch rules.
module tb_rr_dispatcher;

   localparam int N = 4;
   localparam int W = 64;
   localparam int D = 2;

   typedef logic [W:0] ent_t;

   logic           clk;
   logic           rst_n;
   logic           disp_enable;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic           in_last;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_last;

   int n_checks = 0;
   int n_fail   = 0;

   ent_t mq [N][$];
   int   m_ptr    = N - 1;
   bit   m_locked = 0;
   int   m_tgt    = 0;

   rr_dispatcher #(.NUM_OUT(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_disp_enable (disp_enable),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_data     (in_data),
      .i_in_last     (in_last),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_data    (out_data),
      .o_out_last    (out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scan outputs cyclically starting after the last served one; -1 when none has room.
   function automatic int m_select();
      if (!disp_enable) return (mq[0].size() < D) ? 0 : -1;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (mq[j].size() < D) return j;
      end
      return -1;
   endfunction

   function automatic bit m_ready();
      if (!rst_n) return 1'b0;
      if (m_locked) return mq[m_tgt].size() < D;
      return m_select() >= 0;
   endfunction

   task automatic cycle();
      bit acc;
      int tgt;
      acc = in_valid && m_ready();
      tgt = m_locked ? m_tgt : m_select();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         m_ptr    = N - 1;
         m_locked = 0;
         m_tgt    = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
         end
         if (acc) begin
            mq[tgt].push_back({in_last, in_data});
            if (in_last) begin
               m_locked = 0;
               m_ptr    = tgt;
            end else begin
               m_locked = 1;
               m_tgt    = tgt;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic reset_dut();
      rst_n       = 1'b0;
      disp_enable = 1'b1;
      out_ready   = '1;
      drive(1'b0, '0, 1'b0);
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 64'h1234, 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      cycle();
      n_checks++;
      if (out_valid !== '0) begin
         n_fail++; $display("FAIL reset_out_valid got %b want 0000", out_valid);
      end
      n_checks++;
      if (out_last !== '0) begin
         n_fail++; $display("FAIL reset_out_last got %b want 0000", out_last);
      end
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
      end
      cycle();
   endtask

   task automatic test_rotation();
      int ch;
      reset_dut();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 64'hD0 + 64'(k), 1'b1);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rotation_ready k=%0d got %b want 1", k, in_ready);
         end
         if (k == 0) begin
            n_checks++;
            if (out_valid !== '0) begin
               n_fail++; $display("FAIL rotation_no_bypass got %b want 0000", out_valid);
            end
         end
         cycle();
         ch = k % N;
         n_checks++;
         if (out_valid !== 4'(1 << ch)) begin
            n_fail++; $display("FAIL rotation_valid k=%0d got %b want %b", k, out_valid, 4'(1 << ch));
         end
         n_checks++;
         if (out_data[ch*W +: W] !== 64'hD0 + 64'(k)) begin
            n_fail++; $display("FAIL rotation_data k=%0d got %h want %h", k, out_data[ch*W +: W], 64'hD0 + 64'(k));
         end
      end
      drive(1'b0, '0, 1'b0);
      cycle();
   endtask

   task automatic test_multi_flit();
      int   chs   [4] = '{0, 0, 0, 1};
      logic lasts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 64'hA0 + 64'(k), lasts[k]);
         cycle();
         n_checks++;
         if (out_valid !== 4'(1 << chs[k])) begin
            n_fail++; $display("FAIL multi_valid k=%0d got %b want %b", k, out_valid, 4'(1 << chs[k]));
         end
         n_checks++;
         if (out_last !== (lasts[k] ? 4'(1 << chs[k]) : 4'b0)) begin
            n_fail++; $display("FAIL multi_last k=%0d got %b want %b", k, out_last, lasts[k] ? 4'(1 << chs[k]) : 4'b0);
         end
         n_checks++;
         if (out_data[chs[k]*W +: W] !== 64'hA0 + 64'(k)) begin
            n_fail++; $display("FAIL multi_data k=%0d got %h want %h", k, out_data[chs[k]*W +: W], 64'hA0 + 64'(k));
         end
      end
      drive(1'b0, '0, 1'b0);
      cycle();
   endtask

   task automatic test_skip_full();
      int chs  [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};
      int chs2 [4]  = '{1, 2, 3, 0};
      reset_dut();
      out_ready = 4'b1101;
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 64'hB00 + 64'(k), 1'b1);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skip_ready k=%0d got %b want 1", k, in_ready);
         end
         cycle();
         n_checks++;
         if (out_valid[chs[k]] !== 1'b1) begin
            n_fail++; $display("FAIL skip_valid k=%0d ch=%0d got %b want 1", k, chs[k], out_valid[chs[k]]);
         end
         if (chs[k] != 1) begin
            n_checks++;
            if (out_data[chs[k]*W +: W] !== 64'hB00 + 64'(k)) begin
               n_fail++; $display("FAIL skip_data k=%0d got %h want %h", k, out_data[chs[k]*W +: W], 64'hB00 + 64'(k));
            end
         end
      end
      n_checks++;
      if (out_data[1*W +: W] !== 64'hB01) begin
         n_fail++; $display("FAIL skip_held_head got %h want %h", out_data[1*W +: W], 64'hB01);
      end
      out_ready = '1;
      drive(1'b0, '0, 1'b0);
      cycle();
      cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 64'hC00 + 64'(k), 1'b1);
         cycle();
         n_checks++;
         if (out_valid !== 4'(1 << chs2[k])) begin
            n_fail++; $display("FAIL resume_valid k=%0d got %b want %b", k, out_valid, 4'(1 << chs2[k]));
         end
         n_checks++;
         if (out_data[chs2[k]*W +: W] !== 64'hC00 + 64'(k)) begin
            n_fail++; $display("FAIL resume_data k=%0d got %h want %h", k, out_data[chs2[k]*W +: W], 64'hC00 + 64'(k));
         end
      end
      drive(1'b0, '0, 1'b0);
      cycle();
   endtask

   task automatic test_locked_stall();
      reset_dut();
      drive(1'b1, 64'hE0, 1'b1);
      cycle();
      drive(1'b1, 64'hE1, 1'b1);
      cycle();
      out_ready = 4'b1011;
      drive(1'b1, 64'hF0, 1'b0);
      cycle();
      drive(1'b1, 64'hF1, 1'b0);
      cycle();
      drive(1'b1, 64'hF2, 1'b1);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL locked_stall_ready got %b want 0", in_ready);
      end
      n_checks++;
      if (out_valid !== 4'b0100) begin
         n_fail++; $display("FAIL locked_stall_valid got %b want 0100", out_valid);
      end
      cycle();
      out_ready[2] = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL locked_pop_cycle_ready got %b want 0", in_ready);
      end
      cycle();
      out_ready[2] = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL locked_release_ready got %b want 1", in_ready);
      end
      cycle();
      n_checks++;
      if (out_data[2*W +: W] !== 64'hF1) begin
         n_fail++; $display("FAIL locked_head got %h want %h", out_data[2*W +: W], 64'hF1);
      end
      out_ready = '1;
      drive(1'b1, 64'hF9, 1'b1);
      cycle();
      n_checks++;
      if (out_valid[3] !== 1'b1 || out_data[3*W +: W] !== 64'hF9) begin
         n_fail++; $display("FAIL locked_next_pkt got valid=%b data=%h want valid=1 data=%h", out_valid[3], out_data[3*W +: W], 64'hF9);
      end
      drive(1'b0, '0, 1'b0);
      cycle();
      cycle();
   endtask

   task automatic test_disp_disable();
      logic lasts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      reset_dut();
      disp_enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) disp_enable = 1'b1;
         drive(1'b1, 64'h500 + 64'(k), lasts[k]);
         cycle();
         n_checks++;
         if (out_valid !== 4'b0001 || out_data[W-1:0] !== 64'h500 + 64'(k)) begin
            n_fail++; $display("FAIL disable_ch0 k=%0d got valid=%b data=%h want valid=0001 data=%h", k, out_valid, out_data[W-1:0], 64'h500 + 64'(k));
         end
      end
      drive(1'b1, 64'h5FF, 1'b1);
      cycle();
      n_checks++;
      if (out_valid !== 4'b0010 || out_data[1*W +: W] !== 64'h5FF) begin
         n_fail++; $display("FAIL disable_next_pkt got valid=%b data=%h want valid=0010 data=%h", out_valid, out_data[1*W +: W], 64'h5FF);
      end
      drive(1'b0, '0, 1'b0);
      cycle();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      out_ready = '0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 64'h700 + 64'(k), 1'b1);
         cycle();
      end
      drive(1'b1, 64'h780, 1'b0);
      cycle();
      n_checks++;
      if (out_valid !== 4'b1111) begin
         n_fail++; $display("FAIL midreset_prefill got %b want 1111", out_valid);
      end
      rst_n = 1'b0;
      drive(1'b1, 64'h781, 1'b0);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL midreset_ready got %b want 0", in_ready);
      end
      cycle();
      n_checks++;
      if (out_valid !== '0 || out_last !== '0) begin
         n_fail++; $display("FAIL midreset_flush got valid=%b last=%b want 0000/0000", out_valid, out_last);
      end
      rst_n     = 1'b1;
      out_ready = '1;
      drive(1'b1, 64'h7AA, 1'b1);
      cycle();
      n_checks++;
      if (out_valid !== 4'b0001 || out_data[W-1:0] !== 64'h7AA) begin
         n_fail++; $display("FAIL midreset_first_pkt got valid=%b data=%h want valid=0001 data=%h", out_valid, out_data[W-1:0], 64'h7AA);
      end
      drive(1'b0, '0, 1'b0);
      cycle();
   endtask

   task automatic test_random();
      logic [N-1:0] exp_v;
      logic [N-1:0] exp_l;
      bit           exp_r;
      int           rdy_bias;
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) rdy_bias = $urandom_range(2, 9);
         rst_n = ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 19) == 0) disp_enable = ~disp_enable;
         for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(0, 9) < rdy_bias);
         drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 2) == 0);
         #1;
         exp_r = m_ready();
         n_checks++;
         if (in_ready !== exp_r) begin
            n_fail++; $display("FAIL random_ready c=%0d got %b want %b", c, in_ready, exp_r);
         end
         cycle();
         exp_v = '0;
         exp_l = '0;
         for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0) begin
               exp_v[i] = 1'b1;
               exp_l[i] = mq[i][0][W];
            end
         end
         n_checks++;
         if (out_valid !== exp_v) begin
            n_fail++; $display("FAIL random_valid c=%0d got %b want %b", c, out_valid, exp_v);
         end
         n_checks++;
         if (out_last !== exp_l) begin
            n_fail++; $display("FAIL random_last c=%0d got %b want %b", c, out_last, exp_l);
         end
         for (int i = 0; i < N; i++) begin
            if (exp_v[i]) begin
               n_checks++;
               if (out_data[i*W +: W] !== mq[i][0][W-1:0]) begin
                  n_fail++; $display("FAIL random_data c=%0d ch=%0d got %h want %h", c, i, out_data[i*W +: W], mq[i][0][W-1:0]);
               end
            end
         end
      end
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0);
      cycle();
   endtask

   initial begin
      rst_n       = 1'b0;
      disp_enable = 1'b1;
      out_ready   = '1;
      drive(1'b0, '0, 1'b0);
      test_reset();
      test_rotation();
      test_multi_flit();
      test_skip_full();
      test_locked_stall();
      test_disp_disable();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
